// File: rtl/ab_seq_pkg.sv
// ab_seq_pkg: shared types and helpers for the a ##1 b stimulus player.
//   state_t  : playback FSM states (IDLE, PLAY, DRAIN)
//   entry_t  : one buffered stimulus pair {a, b}
//   sat_inc  : saturating increment of a counter that is w bits wide
package ab_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic a;
        logic b;
    } entry_t;

    // The value is carried in 32 bits so that one helper serves any counter
    // width up to 32. When w is 32, the shift wraps to 0, so max_v becomes
    // all-ones, which is still correct.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ab_pair_checker.sv
// ab_pair_checker: judges one a ##1 b attempt per valid cycle.
//   clk, rst      : clock, asynchronous active-high reset
//   a_i, b_i      : the stimulus currently being played
//   att_vld_i     : an attempt starts this cycle (entry att_idx_i on a_i/b_i)
//   att_idx_i     : buffer index of the attempt starting this cycle
//   fail_a_o      : attempt starting this cycle has a = 0 (index fail_a_idx_o)
//   pass_o        : attempt from last cycle saw b = 1 now (index res_idx_o)
//   fail_b_o      : attempt from last cycle saw b = 0 now (index res_idx_o)
// All strobes are combinational and valid in the cycle the decision is made.
module ab_pair_checker #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             att_vld_i,
    input  logic [IDX_W-1:0] att_idx_i,
    output logic             pass_o,
    output logic             fail_a_o,
    output logic             fail_b_o,
    output logic [IDX_W-1:0] fail_a_idx_o,
    output logic [IDX_W-1:0] res_idx_o
);

    // The only attempt that can be waiting on b is the one started last cycle.
    logic             pend_vld_q;
    logic [IDX_W-1:0] pend_idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld_q <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            pend_vld_q <= att_vld_i & a_i;
            pend_idx_q <= att_idx_i;
        end
    end

    assign fail_a_o     = att_vld_i & ~a_i;
    assign fail_a_idx_o = att_idx_i;
    assign pass_o       = pend_vld_q & b_i;
    assign fail_b_o     = pend_vld_q & ~b_i;
    assign res_idx_o    = pend_idx_q;

endmodule

// File: rtl/ab_seq_player.sv
// ab_seq_player: buffers (a, b) pairs, plays them back one per clock, and
// counts the results of every a ##1 b attempt in the run.
//   clk, rst                  : clock, asynchronous active-high reset
//   load_valid/load_a/load_b  : write one entry; load_ready accepts it
//   clear                     : empty the buffer (IDLE only, beats a load)
//   start                     : begin a run (IDLE only)
//   busy, done                : run in progress / one-cycle end-of-run pulse
//   a, b                      : registered played stimulus
//   pass_cnt, fail_a_cnt,
//   fail_b_cnt                : saturating result counters
//   first_fail_vld/idx        : first failing attempt of the run
//   dbg_state                 : current FSM state, for observation only
//
// Load handshake: an entry is written exactly in a cycle where load_valid and
// load_ready are both high (and clear is low). load_ready does not depend on
// load_valid; it is high only in IDLE while the buffer is not full. A cycle in
// which load_valid is high and load_ready is low is simply dropped.
module ab_seq_player
    import ab_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    input  logic                     load_a,
    input  logic                     load_b,
    output logic                     load_ready,
    input  logic                     clear,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     a,
    output logic                     b,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_a_cnt,
    output logic [CNT_W-1:0]         fail_b_cnt,
    output logic                     first_fail_vld,
    output logic [$clog2(DEPTH)-1:0] first_fail_idx,
    output state_t                   dbg_state
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_BW = IDX_W + 1;   // count runs 0..DEPTH inclusive

    state_t             state_q;
    logic [CNT_BW-1:0]  count_q, count_d;
    logic [IDX_W-1:0]   cur_idx_q, nxt_idx;
    logic               a_q, b_q, done_q, empty_q;
    logic [CNT_W-1:0]   pass_q, fail_a_q, fail_b_q;
    logic [CNT_W-1:0]   pass_d, fail_a_d, fail_b_d;
    logic               ffv_q, ffv_d;
    logic [IDX_W-1:0]   ffi_q, ffi_d;
    entry_t             mem_q [DEPTH];
    entry_t             first_entry;
    logic               load_accept, last_entry;

    logic               chk_pass, chk_fail_a, chk_fail_b;
    logic [IDX_W-1:0]   chk_fail_a_idx, chk_res_idx;

    assign load_ready  = (state_q == IDLE) && (count_q < CNT_BW'(DEPTH));
    assign load_accept = load_valid && load_ready && !clear;

    always_comb begin
        count_d = count_q;
        if (state_q == IDLE) begin
            if (clear) begin
                count_d = '0;
            end else if (load_accept) begin
                count_d = count_q + CNT_BW'(1);
            end
        end
    end

    // A load that arrives together with start into an empty buffer is entry 0
    // and has not reached mem_q yet, so it is forwarded.
    assign first_entry = (count_q == '0) ? entry_t'({load_a, load_b}) : mem_q[0];
    assign nxt_idx     = cur_idx_q + IDX_W'(1);
    assign last_entry  = ({1'b0, cur_idx_q} == (count_q - CNT_BW'(1)));

    always_ff @(posedge clk) begin
        if (load_accept) begin
            mem_q[count_q[IDX_W-1:0]] <= {load_a, load_b};
        end
    end

    ab_pair_checker #(.IDX_W(IDX_W)) u_checker (
        .clk          (clk),
        .rst          (rst),
        .a_i          (a_q),
        .b_i          (b_q),
        .att_vld_i    (state_q == PLAY),
        .att_idx_i    (cur_idx_q),
        .pass_o       (chk_pass),
        .fail_a_o     (chk_fail_a),
        .fail_b_o     (chk_fail_b),
        .fail_a_idx_o (chk_fail_a_idx),
        .res_idx_o    (chk_res_idx)
    );

    always_comb begin
        pass_d   = pass_q;
        fail_a_d = fail_a_q;
        fail_b_d = fail_b_q;
        ffv_d    = ffv_q;
        ffi_d    = ffi_q;
        if (chk_pass)   pass_d   = CNT_W'(sat_inc(32'(pass_q),   CNT_W));
        if (chk_fail_a) fail_a_d = CNT_W'(sat_inc(32'(fail_a_q), CNT_W));
        if (chk_fail_b) fail_b_d = CNT_W'(sat_inc(32'(fail_b_q), CNT_W));
        // A b-failure in this cycle belongs to the previous entry, so it takes
        // precedence over an a-failure of the current entry.
        if (!ffv_q) begin
            if (chk_fail_b) begin
                ffv_d = 1'b1;
                ffi_d = chk_res_idx;
            end else if (chk_fail_a) begin
                ffv_d = 1'b1;
                ffi_d = chk_fail_a_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            cur_idx_q <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            done_q    <= 1'b0;
            empty_q   <= 1'b0;
            pass_q    <= '0;
            fail_a_q  <= '0;
            fail_b_q  <= '0;
            ffv_q     <= 1'b0;
            ffi_q     <= '0;
        end else begin
            count_q  <= count_d;
            done_q   <= 1'b0;
            empty_q  <= 1'b0;
            pass_q   <= pass_d;
            fail_a_q <= fail_a_d;
            fail_b_q <= fail_b_d;
            ffv_q    <= ffv_d;
            ffi_q    <= ffi_d;
            case (state_q)
                IDLE: begin
                    a_q <= 1'b0;
                    b_q <= 1'b0;
                    // An empty run still takes one idle cycle before done.
                    if (empty_q) done_q <= 1'b1;
                    if (start) begin
                        pass_q   <= '0;
                        fail_a_q <= '0;
                        fail_b_q <= '0;
                        ffv_q    <= 1'b0;
                        ffi_q    <= '0;
                        if (count_d == '0) begin
                            empty_q <= 1'b1;
                        end else begin
                            state_q   <= PLAY;
                            cur_idx_q <= '0;
                            a_q       <= first_entry.a;
                            b_q       <= first_entry.b;
                        end
                    end
                end
                PLAY: begin
                    if (last_entry) begin
                        state_q <= DRAIN;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                    end else begin
                        cur_idx_q <= nxt_idx;
                        a_q       <= mem_q[nxt_idx].a;
                        b_q       <= mem_q[nxt_idx].b;
                    end
                end
                DRAIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign a              = a_q;
    assign b              = b_q;
    assign pass_cnt       = pass_q;
    assign fail_a_cnt     = fail_a_q;
    assign fail_b_cnt     = fail_b_q;
    assign first_fail_vld = ffv_q;
    assign first_fail_idx = ffi_q;
    assign dbg_state      = state_q;

endmodule

// File: doc/ab_seq_player.md
# ab_seq_player

Stimulus sequencer and inline checker for the two-signal `a ##1 b` protocol.
- Software loads a small buffer with (a, b) pairs, then issues start.
- The block plays one pair per clock on its `a`/`b` outputs.
- It evaluates every played cycle as an `a ##1 b` attempt and reports pass and fail counts.
- It sits between the testbench/config side and the DUT or monitor driven by `a`/`b`.

## Interface
Parameters:
- `DEPTH`, 16: pattern buffer entries (power of two, ≥2)
- `CNT_W`, 8: width of result counters

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `load_valid`  in  1  write one pattern entry
- `load_a`, `load_b`  in  1 each  entry contents
- `load_ready`  out  1  entry accepted when `load_valid && load_ready`
- `clear`  in  1  empty the buffer (IDLE only)
- `start`  in  1  begin playback (IDLE only)
- `busy`  out  1  high in PLAY and DRAIN
- `done`  out  1  one-cycle pulse at end of run
- `a`, `b`  out  1 each  played stimulus, registered
- `pass_cnt`, `fail_a_cnt`, `fail_b_cnt`  out  CNT_W each  saturating result counters
- `first_fail_vld`  out  1  at least one failure this run
- `first_fail_idx`  out  $clog2(DEPTH)  entry index of first failing attempt

## Operation
- Reset values:
  - state IDLE, buffer count 0.
  - `a`, `b`, `busy`, `done` all 0.
  - All counters 0, `first_fail_vld` 0, `first_fail_idx` 0.
  - `load_ready` is 1 after reset.
- `load_ready` = IDLE and count < DEPTH.
  - An accepted load writes entry[count] and increments count.
  - At full, loads are ignored.
  - Loads offered while busy are ignored (`load_ready` 0).
- `clear` in IDLE sets count to 0. `clear` is ignored while busy.
- If `clear` and `load_valid` arrive together, `clear` wins and the entry is discarded.
- `start` in IDLE with count = 0:
  - no playback;
  - counters are cleared;
  - `done` pulses the next cycle.
- `start` in IDLE with count > 0:
  - counters and `first_fail_*` are cleared;
  - `idx` is set to 0;
  - state goes to PLAY.
- `start` while busy is ignored. If `start` and `load_valid` arrive together, the load is applied first and the new entry is played.
- PLAY:
  - Each cycle, `a`/`b` = entry[idx] and `idx` increments.
  - After `idx` = count−1, state goes to DRAIN.
- DRAIN: lasts one cycle with `a` = `b` = 0, so the last attempt's `b` resolves. Then state returns to IDLE and `done` pulses.
- The buffer is retained after a run, so a repeated `start` replays the same pattern.
- Attempt rule: one attempt per PLAY cycle k (entry k).
  - If `a` = 0 in cycle k: fail, counted in `fail_a_cnt`.
  - If `a` = 1: resolved on `b` in cycle k+1. `b` = 1 counts in `pass_cnt`; `b` = 0 counts in `fail_b_cnt`.
  - No attempts start in DRAIN.
- Simultaneous events:
  - A `fail_a` of attempt k and the `b` resolution of attempt k−1 can occur in the same cycle. Both are counted.
  - `first_fail_idx` takes the lower index, k−1, when both fail.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Reset asserted mid-run aborts immediately to the reset values; the buffer count returns to 0.

## Timing
- `start` sampled at edge T → entry 0 drives `a`/`b` in cycle T+1 (one-cycle latency).
- A run of N entries:
  - `busy` high for N+1 cycles (T+1 … T+N+1);
  - `done` high in cycle T+N+2.
- Counter updates are registered:
  - a `fail_a` decided in cycle k is visible in cycle k+1;
  - pass/`fail_b` for attempt k is visible in cycle k+2.
- All counters and `first_fail_*` are final and stable when `done` = 1, and hold until the next `start` or reset.

## Structure
- Package `ab_seq_pkg`:
  - state enum {IDLE, PLAY, DRAIN};
  - entry struct {a, b};
  - helper function for saturating increment.
- Sub-module `ab_pair_checker`:
  - inputs: `a`, `b`, attempt-valid, attempt index;
  - holds the one-cycle pending attempt;
  - emits `pass`/`fail_a`/`fail_b` strobes with their index.
- The top level holds the buffer, FSM and counters.

## Test plan
- Load (1,0),(1,1),(0,0), start → `a`/`b` = 1/0, 1/1, 0/0, then 0/0 drain; `done` at T+5; pass=1, fail_a=1, fail_b=1, first_fail_idx=1.
- Load 16 entries of (1,1), then a 17th load → 17th rejected (`load_ready` 0); run gives pass=15, fail_b=1 (last entry fails in DRAIN), first_fail_idx=15.
- Start with an empty buffer → no `busy`; `done` at T+2; all counters 0, `first_fail_vld` 0.
- Load (0,1),(1,0) → at cycle 2 fail_a of idx 0 and fail_b of idx... sequence check: fail_a=1 (idx0), fail_b=1 (idx1); `first_fail_idx`=0.
- CNT_W=2, 8 entries of (0,0) → `fail_a_cnt` saturates at 3.
- Assert `rst` in the middle of PLAY → all outputs immediately 0, count 0; subsequent `start` gives `done` with zero counters.
